// File: rtl/seq_detect_pkg.sv
// Shared definitions for the parametrised serial sequence detector.
//   overlap_e  : run-time detection mode as seen on the Overlap input
//   fill_width : width of the history fill counter for a given pattern length
package seq_detect_pkg;

   typedef enum logic {
      OVERLAP_OFF = 1'b0,
      OVERLAP_ON  = 1'b1
   } overlap_e;

   // Fill counts 0..pat_w-1; never narrower than one bit.
   function automatic int unsigned fill_width(input int unsigned pat_w);
      int unsigned w;
      w = $clog2(pat_w);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter.
//   Clk   : clock, rising edge
//   Rst   : asynchronous reset, active-high, clears Count
//   Clr   : synchronous clear; an Inc in the same cycle leaves Count at 1
//   Inc   : increment request, ignored once Count is all-ones
//   Count : current count value
module sat_counter #(
   parameter int unsigned W = 8
) (
   input  logic         Clk,
   input  logic         Rst,
   input  logic         Clr,
   input  logic         Inc,
   output logic [W-1:0] Count
);

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         Count <= '0;
      end else if (Clr) begin
         Count <= Inc ? W'(1) : '0;
      end else if (Inc && (Count != '1)) begin
         Count <= Count + W'(1);
      end
   end

endmodule

// File: rtl/seq_detect_param.sv
// Parametrised serial sequence detector.
// Matches a run-time loadable PAT_W-bit pattern (first received bit = MSB)
// against the stream of accepted Din bits, with overlapping or
// non-overlapping detection chosen per match by Overlap.
//   Clk     : clock, rising edge
//   Rst     : asynchronous reset, active-high
//   En      : Din qualifier; a bit is accepted when En=1 and PatLoad=0
//   Din     : serial data bit
//   Overlap : 1 overlapping, 0 non-overlapping detection
//   PatLoad : load PatIn as the pattern, flushing history
//   PatIn   : new pattern value
//   CntClr  : synchronous clear of Count
//   Q       : registered match pulse, one cycle after the completing bit
//   Hit     : combinational match on the completing bit
//   Count   : saturating number of matches since reset/CntClr
module seq_detect_param
   import seq_detect_pkg::*;
#(
   parameter int unsigned          PAT_W       = 3,
   parameter logic [PAT_W-1:0]     DEFAULT_PAT = PAT_W'(3'b101),
   parameter int unsigned          CNT_W       = 8
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             En,
   input  logic             Din,
   input  logic             Overlap,
   input  logic             PatLoad,
   input  logic [PAT_W-1:0] PatIn,
   input  logic             CntClr,
   output logic             Q,
   output logic             Hit,
   output logic [CNT_W-1:0] Count
);

   localparam int unsigned     FW        = fill_width(PAT_W);
   localparam logic [FW-1:0]   FILL_LAST = FW'(PAT_W - 1);

   logic [PAT_W-1:0] pattern;
   logic [PAT_W-2:0] hist;
   logic [FW-1:0]    fill;

   logic             accept;
   logic             match_now;
   logic [PAT_W-1:0] hist_din;
   logic [PAT_W-2:0] hist_shift;
   logic [FW-1:0]    fill_nxt;
   overlap_e         ovl_mode;

   assign accept     = En & ~PatLoad;
   assign hist_din   = {hist, Din};
   // Oldest bit falls off the top; also correct for PAT_W=2 where hist is 1 bit.
   assign hist_shift = hist_din[PAT_W-2:0];
   assign ovl_mode   = overlap_e'(Overlap);

   assign match_now  = accept & (fill == FILL_LAST) & (hist_din == pattern);
   assign Hit        = match_now & ~Rst;

   always_comb begin
      fill_nxt = fill;
      if (match_now) begin
         // Overlapping keeps the history usable; non-overlapping demands PAT_W fresh bits.
         fill_nxt = (ovl_mode == OVERLAP_ON) ? FILL_LAST : '0;
      end else if (fill != FILL_LAST) begin
         fill_nxt = fill + FW'(1);
      end
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         pattern <= DEFAULT_PAT;
         hist    <= '0;
         fill    <= '0;
         Q       <= 1'b0;
      end else begin
         Q <= match_now;
         if (PatLoad) begin
            pattern <= PatIn;
            hist    <= '0;
            fill    <= '0;
         end else if (En) begin
            hist <= hist_shift;
            fill <= fill_nxt;
         end
      end
   end

   sat_counter #(
      .W (CNT_W)
   ) u_count (
      .Clk   (Clk),
      .Rst   (Rst),
      .Clr   (CntClr),
      .Inc   (match_now),
      .Count (Count)
   );

endmodule

// File: tb/tb_seq_detect_param.sv
module tb_seq_detect_param;

   typedef struct {
      bit         sel;
      int         idx;
      logic       hit;
      logic       q;
      logic [7:0] cnt;
   } exp_t;

   logic       Clk = 1'b0;
   logic       Rst = 1'b1;

   logic       en_a = 1'b0, din_a = 1'b0, ovl_a = 1'b0, pl_a = 1'b0, clr_a = 1'b0;
   logic [2:0] pin_a = '0;
   logic       q_a, hit_a;
   logic [7:0] cnt_a;

   logic       en_b = 1'b0, din_b = 1'b0, ovl_b = 1'b0, pl_b = 1'b0, clr_b = 1'b0;
   logic [2:0] pin_b = '0;
   logic       q_b, hit_b;
   logic [1:0] cnt_b;

   exp_t       sb_a[$];
   exp_t       sb_b[$];
   int         n_vec  = 0;
   int         n_miss = 0;
   int         n_push = 0;

   always #5 Clk = ~Clk;

   seq_detect_param #(
      .PAT_W       (3),
      .DEFAULT_PAT (3'b101),
      .CNT_W       (8)
   ) dut_a (
      .Clk     (Clk),
      .Rst     (Rst),
      .En      (en_a),
      .Din     (din_a),
      .Overlap (ovl_a),
      .PatLoad (pl_a),
      .PatIn   (pin_a),
      .CntClr  (clr_a),
      .Q       (q_a),
      .Hit     (hit_a),
      .Count   (cnt_a)
   );

   seq_detect_param #(
      .PAT_W       (3),
      .DEFAULT_PAT (3'b101),
      .CNT_W       (2)
   ) dut_b (
      .Clk     (Clk),
      .Rst     (Rst),
      .En      (en_b),
      .Din     (din_b),
      .Overlap (ovl_b),
      .PatLoad (pl_b),
      .PatIn   (pin_b),
      .CntClr  (clr_b),
      .Q       (q_b),
      .Hit     (hit_b),
      .Count   (cnt_b)
   );

   // One cycle of stimulus: drive inputs just after the rising edge and queue
   // what the selected DUT must show in this cycle (Hit for these inputs,
   // Q/Count as left by the edge just taken).
   task automatic step(input bit sel, input logic rst, input logic en, input logic din,
                       input logic ovl, input logic pl, input logic [2:0] pin,
                       input logic clr, input logic ehit, input logic eq,
                       input logic [7:0] ecnt);
      exp_t e;
      @(posedge Clk);
      #1;
      Rst = rst;
      if (sel) begin
         en_a = 1'b0; din_a = 1'b0; pl_a = 1'b0; clr_a = 1'b0;
         en_b = en; din_b = din; ovl_b = ovl; pl_b = pl; pin_b = pin; clr_b = clr;
      end else begin
         en_b = 1'b0; din_b = 1'b0; pl_b = 1'b0; clr_b = 1'b0;
         en_a = en; din_a = din; ovl_a = ovl; pl_a = pl; pin_a = pin; clr_a = clr;
      end
      e.sel = sel; e.idx = n_push; e.hit = ehit; e.q = eq; e.cnt = ecnt;
      n_push++;
      if (sel) sb_b.push_back(e);
      else     sb_a.push_back(e);
   endtask

   task automatic compare(input exp_t e, input logic hit, input logic q, input logic [7:0] cnt);
      bit bad;
      bad = 1'b0;
      n_vec++;
      if (hit !== e.hit) begin
         $display("FAIL hit dut%s v%0d: got %b expected %b", e.sel ? "B" : "A", e.idx, hit, e.hit);
         bad = 1'b1;
      end
      if (q !== e.q) begin
         $display("FAIL q dut%s v%0d: got %b expected %b", e.sel ? "B" : "A", e.idx, q, e.q);
         bad = 1'b1;
      end
      if (cnt !== e.cnt) begin
         $display("FAIL count dut%s v%0d: got %0d expected %0d", e.sel ? "B" : "A", e.idx, cnt, e.cnt);
         bad = 1'b1;
      end
      if (bad) n_miss++;
   endtask

   // Monitor: outputs are presented every cycle; sample mid-cycle.
   always @(negedge Clk) begin
      exp_t e;
      if (sb_a.size() > 0) begin
         e = sb_a.pop_front();
         compare(e, hit_a, q_a, cnt_a);
      end
      if (sb_b.size() > 0) begin
         e = sb_b.pop_front();
         compare(e, hit_b, q_b, cnt_b);
      end
   end

   initial begin
      //    sel rst en din ovl pl pin     clr  hit q  cnt
      // reset state
      step(0, 1, 0, 0, 1, 0, 3'b000, 0,   0, 0, 0);
      // overlap on: 1,0,1,0,1 -> hits on bits 3 and 5
      step(0, 0, 1, 1, 1, 0, 3'b000, 0,   0, 0, 0);
      step(0, 0, 1, 0, 1, 0, 3'b000, 0,   0, 0, 0);
      step(0, 0, 1, 1, 1, 0, 3'b000, 0,   1, 0, 0);
      step(0, 0, 1, 0, 1, 0, 3'b000, 0,   0, 1, 1);
      step(0, 0, 1, 1, 1, 0, 3'b000, 0,   1, 0, 1);
      step(0, 0, 0, 0, 1, 0, 3'b000, 0,   0, 1, 2);
      step(0, 0, 0, 0, 1, 0, 3'b000, 1,   0, 0, 2);
      // flush history (PatLoad wins over En with Din=1)
      step(0, 0, 1, 1, 0, 1, 3'b101, 0,   0, 0, 0);
      // overlap off: same stream -> single hit on bit 3
      step(0, 0, 1, 1, 0, 0, 3'b000, 0,   0, 0, 0);
      step(0, 0, 1, 0, 0, 0, 3'b000, 0,   0, 0, 0);
      step(0, 0, 1, 1, 0, 0, 3'b000, 0,   1, 0, 0);
      step(0, 0, 1, 0, 0, 0, 3'b000, 0,   0, 1, 1);
      step(0, 0, 1, 1, 0, 0, 3'b000, 0,   0, 0, 1);
      step(0, 0, 0, 0, 0, 0, 3'b000, 0,   0, 0, 1);
      step(0, 0, 0, 0, 0, 1, 3'b101, 1,   0, 0, 1);
      // En gaps: 1,(gap),0,(gap x2, Din=1 ignored),1
      step(0, 0, 1, 1, 1, 0, 3'b000, 0,   0, 0, 0);
      step(0, 0, 0, 0, 1, 0, 3'b000, 0,   0, 0, 0);
      step(0, 0, 1, 0, 1, 0, 3'b000, 0,   0, 0, 0);
      step(0, 0, 0, 1, 1, 0, 3'b000, 0,   0, 0, 0);
      step(0, 0, 0, 1, 1, 0, 3'b000, 0,   0, 0, 0);
      step(0, 0, 1, 1, 1, 0, 3'b000, 0,   1, 0, 0);
      step(0, 0, 0, 1, 1, 0, 3'b000, 0,   0, 1, 1);
      step(0, 0, 0, 0, 1, 0, 3'b000, 0,   0, 0, 1);
      // partial 1,0 then PatLoad 110 on a cycle where 101 would have matched
      step(0, 0, 1, 1, 1, 0, 3'b000, 0,   0, 0, 1);
      step(0, 0, 1, 0, 1, 0, 3'b000, 0,   0, 0, 1);
      step(0, 0, 1, 1, 1, 1, 3'b110, 0,   0, 0, 1);
      step(0, 0, 1, 1, 1, 0, 3'b000, 0,   0, 0, 1);
      step(0, 0, 1, 1, 1, 0, 3'b000, 0,   0, 0, 1);
      step(0, 0, 1, 0, 1, 0, 3'b000, 0,   1, 0, 1);
      // reset while Q is high: Q and Count drop at once, Hit forced low
      step(0, 1, 1, 1, 1, 0, 3'b000, 0,   0, 0, 0);
      // default pattern restored; first bits after reset cannot match
      step(0, 0, 1, 1, 1, 0, 3'b000, 0,   0, 0, 0);
      step(0, 0, 1, 0, 1, 0, 3'b000, 0,   0, 0, 0);
      step(0, 0, 1, 1, 1, 0, 3'b000, 0,   1, 0, 0);
      step(0, 0, 0, 0, 1, 0, 3'b000, 0,   0, 1, 1);
      // 1,0, reset, 1 -> no match
      step(0, 0, 1, 1, 1, 0, 3'b000, 0,   0, 0, 1);
      step(0, 0, 1, 0, 1, 0, 3'b000, 0,   0, 0, 1);
      step(0, 1, 1, 1, 1, 0, 3'b000, 0,   0, 0, 0);
      step(0, 0, 1, 1, 1, 0, 3'b000, 0,   0, 0, 0);
      step(0, 0, 0, 0, 1, 0, 3'b000, 0,   0, 0, 0);
      // 2-bit counter, pattern 111, overlapping on 1111111 -> 5 matches, saturates at 3
      step(1, 0, 0, 0, 1, 1, 3'b111, 0,   0, 0, 0);
      step(1, 0, 1, 1, 1, 0, 3'b000, 0,   0, 0, 0);
      step(1, 0, 1, 1, 1, 0, 3'b000, 0,   0, 0, 0);
      step(1, 0, 1, 1, 1, 0, 3'b000, 0,   1, 0, 0);
      step(1, 0, 1, 1, 1, 0, 3'b000, 0,   1, 1, 1);
      step(1, 0, 1, 1, 1, 0, 3'b000, 0,   1, 1, 2);
      step(1, 0, 1, 1, 1, 0, 3'b000, 0,   1, 1, 3);
      step(1, 0, 1, 1, 1, 0, 3'b000, 0,   1, 1, 3);
      step(1, 0, 0, 0, 1, 0, 3'b000, 0,   0, 1, 3);
      // CntClr together with a match -> Count=1
      step(1, 0, 1, 1, 1, 0, 3'b000, 1,   1, 0, 3);
      step(1, 0, 0, 0, 1, 0, 3'b000, 1,   0, 1, 1);
      step(1, 0, 0, 0, 1, 0, 3'b000, 0,   0, 0, 0);

      for (int i = 0; i < 20; i++) begin
         if (sb_a.size() == 0 && sb_b.size() == 0) break;
         @(posedge Clk);
      end
      if (sb_a.size() != 0 || sb_b.size() != 0) begin
         $display("FAIL drain: %0d expected entries never checked, required 0", sb_a.size() + sb_b.size());
         n_miss++;
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
